// File: rtl/note_sequencer_if.sv
// Command bus between a note producer and note_sequencer.
// Macro: none.
// Signals:
//   cmd_valid  - command offered by the producer
//   cmd_ready  - sequencer can accept a command this cycle
//   cmd_note   - 0..11 = C..B, 12..15 = rest
//   cmd_octave - octave exponent 0..3
//   cmd_dur    - length in ticks, 0 = skip
interface note_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_note;
    logic [1:0] cmd_octave;
    logic [7:0] cmd_dur;

    modport master (
        output cmd_valid, cmd_note, cmd_octave, cmd_dur,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_note, cmd_octave, cmd_dur,
        output cmd_ready
    );
endinterface

// File: rtl/note_sequencer.sv
// Queued note player: buffers note commands, looks up each note's
// frequency through an external calculator and plays it as a square
// wave for cmd_dur ticks.
// Optional feature macro: NOTE_SEQ_GAP_EN inserts GAP_TICKS silent ticks
// after every retired note.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   cmd          - command bus (note_sequencer_if.slave)
//   stop         - synchronous flush/abort
//   calc_note    - note presented to the frequency calculator
//   calc_octave  - octave presented to the frequency calculator
//   calc_freq    - calculator result in Hz (combinational)
//   calc_valid   - calculator result valid
//   tone_out     - square-wave output
//   busy         - a note is loading, playing or in gap
//   note_done    - one-cycle pulse when a command retires
module note_sequencer #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned TICK_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned GAP_TICKS   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    note_sequencer_if.slave cmd,
    input  logic            stop,
    output logic [3:0]      calc_note,
    output logic [1:0]      calc_octave,
    input  logic [19:0]     calc_freq,
    input  logic            calc_valid,
    output logic            tone_out,
    output logic            busy,
    output logic            note_done
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned GW = $clog2(GAP_TICKS + 1);
    localparam int unsigned TW = (GW > 8) ? GW : 8;
    localparam int unsigned EW = 14;
    localparam logic [31:0]   HALF     = 32'(CLK_HZ / 2);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
`ifdef NOTE_SEQ_GAP_EN
        , S_GAP = 2'd3
`endif
    } state_e;

    state_e          state_q, state_d, state_after;
    logic            ph_q, ph_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      dur_q, dur_d;
    logic [3:0]      calc_note_q, calc_note_d;
    logic [1:0]      calc_octave_q, calc_octave_d;
    logic [19:0]     freq_q, freq_d;
    logic [31:0]     acc_q, acc_d, sum;
    logic            tone_q, tone_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [EW-1:0]   head;
    logic            push, pop, avail, pre_wrap;

    assign cmd.cmd_ready = rst_n & (cnt_q != CW'(FIFO_DEPTH)) & ~stop;
    assign push          = cmd.cmd_valid & cmd.cmd_ready;
    assign head          = mem_q[rd_q];

    // Command storage; entry = {note, octave, dur}
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {cmd.cmd_note, cmd.cmd_octave, cmd.cmd_dur};
        end
    end

    // Next-state logic; LOAD takes two cycles (ph_q=0 pop/present, ph_q=1 latch freq)
    always_comb begin
        state_d       = state_q;
        ph_d          = ph_q;
        dur_d         = dur_q;
        calc_note_d   = calc_note_q;
        calc_octave_d = calc_octave_q;
        freq_d        = freq_q;
        pre_d         = pre_q;
        tick_d        = tick_q;
        acc_d         = '0;
        tone_d        = 1'b0;
        sum           = '0;
        pop           = 1'b0;
        avail         = (cnt_q != '0) || push;
        pre_wrap      = (pre_q == PRE_LAST);
`ifdef NOTE_SEQ_GAP_EN
        state_after   = S_GAP;
`else
        state_after   = avail ? S_LOAD : S_IDLE;
`endif

        case (state_q)
            S_IDLE: begin
                if (avail) begin
                    state_d = S_LOAD;
                    ph_d    = 1'b0;
                end
            end
            S_LOAD: begin
                if (!ph_q) begin
                    pop           = 1'b1;
                    calc_note_d   = head[13:10];
                    calc_octave_d = head[9:8];
                    dur_d         = head[7:0];
                    ph_d          = 1'b1;
                end else begin
                    freq_d  = (calc_valid && calc_note_q < 4'd12) ? calc_freq : '0;
                    pre_d   = '0;
                    tick_d  = '0;
                    ph_d    = 1'b0;
                    state_d = (dur_q == '0) ? state_after : S_PLAY;
                end
            end
            S_PLAY: begin
                sum = acc_q + 32'(freq_q);
                if (pre_wrap && tick_q == TW'(dur_q - 8'd1)) begin
                    state_d = state_after;
                    pre_d   = '0;
                    tick_d  = '0;
                end else begin
                    pre_d  = pre_wrap ? '0 : pre_q + PW'(1);
                    tick_d = pre_wrap ? tick_q + TW'(1) : tick_q;
                    if (sum >= HALF) begin
                        acc_d  = sum - HALF;
                        tone_d = ~tone_q;
                    end else begin
                        acc_d  = sum;
                        tone_d = tone_q;
                    end
                end
            end
`ifdef NOTE_SEQ_GAP_EN
            S_GAP: begin
                if (pre_wrap && tick_q == TW'(GAP_TICKS - 1)) begin
                    state_d = avail ? S_LOAD : S_IDLE;
                    ph_d    = 1'b0;
                    pre_d   = '0;
                    tick_d  = '0;
                end else begin
                    pre_d  = pre_wrap ? '0 : pre_q + PW'(1);
                    tick_d = pre_wrap ? tick_q + TW'(1) : tick_q;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        // note_done is registered, so flag the cycle that will be the last PLAY / skip cycle
        done_d = ((state_d == S_PLAY) && (pre_d == PRE_LAST) && (tick_d == TW'(dur_d - 8'd1)))
              || ((state_d == S_LOAD) && ph_d && (dur_d == '0));
        busy_d = (state_d != S_IDLE);

        if (stop) begin
            state_d = S_IDLE;
            ph_d    = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            acc_d   = '0;
            tone_d  = 1'b0;
            pre_d   = '0;
            tick_d  = '0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ph_q          <= 1'b0;
            wr_q          <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
            dur_q         <= '0;
            calc_note_q   <= '0;
            calc_octave_q <= '0;
            freq_q        <= '0;
            acc_q         <= '0;
            tone_q        <= 1'b0;
            pre_q         <= '0;
            tick_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ph_q          <= ph_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
            dur_q         <= dur_d;
            calc_note_q   <= calc_note_d;
            calc_octave_q <= calc_octave_d;
            freq_q        <= freq_d;
            acc_q         <= acc_d;
            tone_q        <= tone_d;
            pre_q         <= pre_d;
            tick_q        <= tick_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign calc_note   = calc_note_q;
    assign calc_octave = calc_octave_q;
    assign tone_out    = tone_q;
    assign busy        = busy_q;
    assign note_done   = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer. A timeline model schedules each
// accepted command (start = max(sequencer free, accept+1); retire = start+1+dur*TICK)
// and predicts busy, note_done, tone_out, calc_* and cmd_ready every cycle.
// Honours NOTE_SEQ_GAP_EN the same way the design does.
`timescale 1ns/1ps
module tb_note_sequencer;
    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned TICK   = 10;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned GAP_T  = 2;
    localparam int HALF = CLK_HZ / 2;
`ifdef NOTE_SEQ_GAP_EN
    localparam int GAPC = GAP_T * TICK;
`else
    localparam int GAPC = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  calc_note;
    logic [1:0]  calc_octave;
    logic [19:0] calc_freq;
    logic        calc_valid;
    logic        tone_out, busy, note_done;

    note_sequencer_if cif();

    note_sequencer #(
        .CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK), .FIFO_DEPTH(DEPTH), .GAP_TICKS(GAP_T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cif), .stop(stop),
        .calc_note(calc_note), .calc_octave(calc_octave),
        .calc_freq(calc_freq), .calc_valid(calc_valid),
        .tone_out(tone_out), .busy(busy), .note_done(note_done)
    );

    always #5 clk = ~clk;

    // Stand-in frequency calculator; note 11 octave 3 reports invalid
    function automatic int calc_hz(input int n, input int o);
        return 130 + 10 * (n % 12) + 60 * o;
    endfunction

    function automatic int model_freq(input int n, input int o);
        if (n >= 12 || (n == 11 && o == 3)) return 0;
        return calc_hz(n, o);
    endfunction

    assign calc_freq  = 20'(calc_hz(int'(calc_note), int'(calc_octave)));
    assign calc_valid = (calc_note < 4'd12) && !(calc_note == 4'd11 && calc_octave == 2'd3);

    typedef struct {
        int acc_c; int start; int done; int endb; int note; int oct; int dur;
    } ent_t;

    ent_t sched[$];
    ent_t keep[$];
    ent_t ne;
    int   cyc = 0, free_at = 0;
    int   n_tests = 0, n_fail = 0;
    int   n_exp_done = 0, n_obs_done = 0;
    int   occ, e_busy, e_done, e_tone, have_calc, e_note, e_oct, jj, ll;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            sched.delete();
            free_at = 0;
        end else begin
            occ = 0; e_busy = 0; e_done = 0; e_tone = 0; have_calc = 0; e_note = 0; e_oct = 0;
            foreach (sched[i]) begin
                if (sched[i].acc_c < cyc && sched[i].start >= cyc) occ++;
                if (cyc >= sched[i].start && cyc <= sched[i].endb) e_busy = 1;
                if (cyc == sched[i].done) e_done = 1;
                if (sched[i].dur > 0 && cyc >= sched[i].start + 2 && cyc <= sched[i].done) begin
                    jj = cyc - sched[i].start - 2;
                    e_tone = ((jj * model_freq(sched[i].note, sched[i].oct)) / HALF) % 2;
                end
                if (cyc >= sched[i].start + 1 && cyc <= sched[i].done) begin
                    have_calc = 1; e_note = sched[i].note; e_oct = sched[i].oct;
                end
            end
            check("busy", longint'(busy), longint'(e_busy));
            check("note_done", longint'(note_done), longint'(e_done));
            check("tone_out", longint'(tone_out), longint'(e_tone));
            check("cmd_ready", longint'(cif.cmd_ready), longint'((occ < DEPTH) && !stop));
            if (have_calc != 0) begin
                check("calc_note", longint'(calc_note), longint'(e_note));
                check("calc_octave", longint'(calc_octave), longint'(e_oct));
            end
            n_exp_done += e_done;
            n_obs_done += int'(note_done);

            if (stop) begin
                keep.delete();
                foreach (sched[i]) begin
                    if (sched[i].done <= cyc) begin
                        ne = sched[i];
                        if (ne.endb > cyc) ne.endb = cyc;
                        keep.push_back(ne);
                    end
                end
                sched = keep;
                free_at = cyc + 1;
            end else if (cif.cmd_valid && cif.cmd_ready) begin
                ne.acc_c = cyc;
                ne.note  = int'(cif.cmd_note);
                ne.oct   = int'(cif.cmd_octave);
                ne.dur   = int'(cif.cmd_dur);
                ll       = ne.dur * TICK;
                ne.start = (free_at > cyc + 1) ? free_at : cyc + 1;
                ne.done  = ne.start + 1 + ll;
                ne.endb  = ne.done + GAPC;
                free_at  = ne.done + 1 + GAPC;
                sched.push_back(ne);
            end
            while (sched.size() > 0 && sched[0].endb < cyc) void'(sched.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input int o, input int d);
        int waited;
        bit acc_ok;
        waited = 0;
        acc_ok = 1'b0;
        cif.cmd_valid  = 1'b1;
        cif.cmd_note   = 4'(n);
        cif.cmd_octave = 2'(o);
        cif.cmd_dur    = 8'(d);
        do begin
            @(negedge clk);
            acc_ok = cif.cmd_ready;
            tick();
            waited++;
        end while (!acc_ok && waited < 2000);
        cif.cmd_valid = 1'b0;
        check("send_accepted", longint'(acc_ok), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((free_at > cyc || busy) && n < 3000) begin
            tick();
            n++;
        end
        check("idle_reached", longint'(busy), 0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_tone", longint'(tone_out), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(note_done), 0);
        check("rst_calc_note", longint'(calc_note), 0);
        check("rst_calc_oct", longint'(calc_octave), 0);
        check("rst_ready", longint'(cif.cmd_ready), 0);
    endtask

    initial begin
        int r, gap;
        cif.cmd_valid  = 1'b0;
        cif.cmd_note   = '0;
        cif.cmd_octave = '0;
        cif.cmd_dur    = '0;
        #1;
        check_reset_values();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // A4-ish note, then a rest, then skip followed by a short note
        send(9, 0, 3);
        wait_idle();
        send(13, 2, 2);
        wait_idle();
        send(4, 1, 0);
        send(5, 1, 1);
        wait_idle();
        send(11, 3, 1);
        wait_idle();

        // Five back-to-back commands while playing: the queue fills and throttles
        for (int i = 0; i < 5; i++) send(i * 2, i % 4, 1 + (i % 2));
        wait_idle();

        // Two dur-1 notes: back-to-back or separated by the gap
        send(0, 0, 1);
        send(7, 2, 1);
        wait_idle();

        // Abort mid-play with two queued
        send(1, 1, 3);
        send(2, 2, 3);
        send(3, 3, 3);
        repeat (6) tick();
        do_stop();
        @(negedge clk);
        check("stop_busy", longint'(busy), 0);
        check("stop_tone", longint'(tone_out), 0);
        check("stop_ready", longint'(cif.cmd_ready), 1);
        tick();
        wait_idle();

        // Randomised traffic with occasional stops
        for (int i = 0; i < 120; i++) begin
            r = int'($urandom_range(0, 39));
            if (r == 0) begin
                do_stop();
            end else begin
                send(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 4)));
            end
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
            repeat (gap) tick();
        end
        wait_idle();

        // Reset in the middle of a note with another queued
        send(2, 1, 4);
        send(6, 0, 2);
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(10, 1, 2);
        wait_idle();

        check("done_count", longint'(n_obs_done), longint'(n_exp_done));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_CYCLES, default 50000, clock cycles per duration tick (1 ms).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, command queue entries (power of two, >=2).
REQ-004 The block SHALL have parameter GAP_TICKS, default 10, silent ticks between notes (used only with NOTE_SEQ_GAP_EN).
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command can be accepted.
REQ-009 cmd_note  input  4  note index 0..11 = C..B; 12..15 = rest.
REQ-010 cmd_octave  input  2  octave multiplier exponent, 0..3.
REQ-011 cmd_dur  input  8  note length in ticks; 0 = skip.
REQ-012 stop  input  1  synchronous flush/abort.
REQ-013 calc_note  output  4  note driven to frequency calculator.
REQ-014 calc_octave  output  2  octave driven to frequency calculator.
REQ-015 calc_freq  input  20  frequency in Hz returned combinationally by calculator.
REQ-016 calc_valid  input  1  calculator result valid (nonzero).
REQ-017 tone_out  output  1  square-wave audio output.
REQ-018 busy  output  1  high while any note is loading, playing or in gap.
REQ-019 note_done  output  1  one-cycle pulse when a command retires.

Function
REQ-020 Command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal (FIFO not full) and not stop.
REQ-021 Simultaneous push and pop on a full FIFO SHALL NOT be allowed (cmd_ready low when full); push and pop on a non-full FIFO SHALL both occur in the same cycle.
REQ-022 States SHALL be IDLE, LOAD, PLAY, GAP; IDLE->LOAD when FIFO non-empty; LOAD pops head.
REQ-023 In LOAD, calc_note/calc_octave SHALL be registered from FIFO head; in the following cycle calc_freq/calc_valid SHALL be latched into an internal freq register (zero if calc_valid low), then state SHALL go to PLAY.
REQ-024 A command accepted into an empty FIFO while IDLE at cycle N SHALL reach PLAY at cycle N+3; busy SHALL rise at N+1.
REQ-025 PLAY SHALL last exactly cmd_dur*TICK_CYCLES cycles; tick prescaler SHALL clear on PLAY entry.
REQ-026 cmd_dur = 0 SHALL skip PLAY: note_done pulses, tone_out stays low, next state as after PLAY.
REQ-027 Tone: 32-bit phase accumulator; each PLAY cycle, if acc+freq >= CLK_HZ/2 then acc <= acc+freq-CLK_HZ/2 and tone_out toggles, else acc <= acc+freq.
REQ-028 Accumulator SHALL clear and tone_out SHALL be driven low on PLAY entry and in every non-PLAY state.
REQ-029 Rest (note 12..15 or calc_valid low) SHALL hold tone_out low for the full duration.
REQ-030 note_done SHALL pulse on the last PLAY cycle (or skip cycle); then GAP if enabled, else LOAD if FIFO non-empty, else IDLE.
REQ-031 stop SHALL, next cycle, empty FIFO, force IDLE, clear accumulator, drive tone_out low, busy low; no note_done pulse for an aborted note.

Reset
REQ-032 On rst_n low: state IDLE, FIFO empty, cmd_ready 0 during reset then 1, tone_out 0, busy 0, note_done 0, calc_note 0, calc_octave 0, freq 0, acc 0, prescaler 0.
REQ-033 Reset asserted mid-PLAY SHALL abort immediately with same values; queued commands lost.

Configuration
REQ-034 With NOTE_SEQ_GAP_EN defined, after each retired note the block SHALL stay in GAP for GAP_TICKS*TICK_CYCLES cycles (tone_out low, busy high), then LOAD or IDLE.
REQ-035 Without NOTE_SEQ_GAP_EN, GAP state SHALL not exist and notes SHALL play back-to-back (LOAD directly after note_done).

Verification (CLK_HZ=1000, TICK_CYCLES=10, FIFO_DEPTH=4, GAP_TICKS=2)
REQ-036 Push note 9, octave 0, dur 3 with calc_freq=220 -> PLAY lasts 30 cycles, tone_out toggles per REQ-027 (~13 toggles), note_done at cycle 30 of PLAY.
REQ-037 Push five commands back-to-back while playing -> cmd_ready drops after FIFO fills; all accepted commands play in order.
REQ-038 Push note 13, dur 2 -> 20 cycles busy with tone_out constantly 0, note_done pulses.
REQ-039 Push dur 0 then dur 1 -> first retires without PLAY, second plays 10 cycles.
REQ-040 Assert stop mid-PLAY with 2 queued -> next cycle IDLE, busy 0, tone_out 0, FIFO empty, no note_done.
REQ-041 Two dur-1 notes with NOTE_SEQ_GAP_EN -> 20 silent busy cycles between them; without macro -> second LOAD immediately after first note_done.
